// File: rtl/ocr_inference_sequencer.sv
// Single-layer linear classifier sequencer: walks pixel/weight memories, accumulates
// one dot product per class, then reports the arg-max digit and its score.
module ocr_inference_sequencer #(
   parameter int unsigned N_INPUTS  = 784,
   parameter int unsigned N_CLASSES = 10,
   parameter int unsigned WEIGHT_W  = 8,
   parameter int unsigned ACC_W     = 32,
   parameter int unsigned DADDR_W   = 10,
   parameter int unsigned WADDR_W   = 13
) (
   input  logic                       i_Clock,
   input  logic                       i_Rst_L,
   input  logic                       i_Data_Ready,
   output logic [DADDR_W-1:0]         o_Data_Addr,
   input  logic signed [31:0]         i_Data_Element,
   output logic [WADDR_W-1:0]         o_Weight_Addr,
   input  logic signed [WEIGHT_W-1:0] i_Weight,
   input  logic                       i_Clear,
   output logic                       o_Busy,
   output logic                       o_Result_Valid,
   output logic [3:0]                 o_Digit,
   output logic signed [ACC_W-1:0]    o_Max_Score,
   output logic [2:0]                 o_State
);

   localparam int unsigned CLS_W = 4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MAC     = 3'd1,
      S_DRAIN   = 3'd2,
      S_COMPARE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t                     state_q, state_d;
   logic                       rdy_q, rdy_d;
   logic [DADDR_W-1:0]         p_q, p_d;
   logic [CLS_W-1:0]           c_q, c_d;
   logic [WADDR_W-1:0]         waddr_q, waddr_d;
   logic signed [ACC_W-1:0]    pix_q, pix_d;
   logic                       mac_v_q, mac_v_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic signed [ACC_W-1:0]    best_q, best_d;
   logic [CLS_W-1:0]           best_dig_q, best_dig_d;
   logic [CLS_W-1:0]           digit_q, digit_d;
   logic signed [ACC_W-1:0]    score_q, score_d;
   logic                       busy_q, busy_d;
   logic                       valid_q, valid_d;
   logic [2:0]                 led_q, led_d;

   logic signed [ACC_W-1:0]    wext_c;
   logic signed [ACC_W-1:0]    prod_c;
   logic                       abort_c;
   logic                       take_c;

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q    <= S_IDLE;
         rdy_q      <= 1'b0;
         p_q        <= '0;
         c_q        <= '0;
         waddr_q    <= '0;
         pix_q      <= '0;
         mac_v_q    <= 1'b0;
         acc_q      <= '0;
         best_q     <= '0;
         best_dig_q <= '0;
         digit_q    <= '0;
         score_q    <= '0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         led_q      <= 3'b001;
      end else begin
         state_q    <= state_d;
         rdy_q      <= rdy_d;
         p_q        <= p_d;
         c_q        <= c_d;
         waddr_q    <= waddr_d;
         pix_q      <= pix_d;
         mac_v_q    <= mac_v_d;
         acc_q      <= acc_d;
         best_q     <= best_d;
         best_dig_q <= best_dig_d;
         digit_q    <= digit_d;
         score_q    <= score_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         led_q      <= led_d;
      end
   end

   // Product is formed at ACC_W: identical to truncating the full-width product.
   always_comb begin
      wext_c  = ACC_W'(i_Weight);
      prod_c  = pix_q * wext_c;
      abort_c = i_Clear || !i_Data_Ready;
      take_c  = (c_q == '0) || (acc_q > best_q);

      state_d    = state_q;
      rdy_d      = i_Data_Ready;
      p_d        = p_q;
      c_d        = c_q;
      waddr_d    = waddr_q;
      pix_d      = pix_q;
      mac_v_d    = 1'b0;
      acc_d      = acc_q;
      best_d     = best_q;
      best_dig_d = best_dig_q;
      digit_d    = digit_q;
      score_d    = score_q;

      case (state_q)
         S_IDLE: begin
            if (!i_Clear && i_Data_Ready && !rdy_q) begin
               state_d = S_MAC;
               p_d     = '0;
               c_d     = '0;
               waddr_d = '0;
               acc_d   = '0;
            end
         end
         S_MAC: begin
            if (!abort_c) begin
               pix_d   = ACC_W'(i_Data_Element);
               mac_v_d = 1'b1;
               if (mac_v_q) acc_d = acc_q + prod_c;
               if (p_q == DADDR_W'(N_INPUTS - 1)) begin
                  p_d     = '0;
                  waddr_d = '0;
                  state_d = S_DRAIN;
               end else begin
                  p_d     = p_q + DADDR_W'(1);
                  waddr_d = waddr_q + WADDR_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (!abort_c) begin
               acc_d   = acc_q + prod_c;
               state_d = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (!abort_c) begin
               if (take_c) begin
                  best_d     = acc_q;
                  best_dig_d = c_q;
               end
               if (c_q == CLS_W'(N_CLASSES - 1)) begin
                  state_d = S_DONE;
                  digit_d = take_c ? c_q : best_dig_q;
                  score_d = take_c ? acc_q : best_q;
               end else begin
                  c_d     = c_q + CLS_W'(1);
                  acc_d   = '0;
                  p_d     = '0;
                  waddr_d = WADDR_W'((32'(c_q) + 32'd1) * N_INPUTS);
                  state_d = S_MAC;
               end
            end
         end
         S_DONE: begin
            if (i_Clear) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Any abort from a busy state discards the partial run.
      if ((state_q == S_MAC || state_q == S_DRAIN || state_q == S_COMPARE) && abort_c) begin
         state_d = S_IDLE;
         p_d     = '0;
         c_d     = '0;
         waddr_d = '0;
         acc_d   = '0;
         mac_v_d = 1'b0;
      end

      busy_d  = (state_d == S_MAC) || (state_d == S_DRAIN) || (state_d == S_COMPARE);
      valid_d = (state_d == S_DONE);
      led_d   = (state_d == S_IDLE) ? 3'b001 : ((state_d == S_DONE) ? 3'b100 : 3'b010);
   end

   assign o_Data_Addr    = p_q;
   assign o_Weight_Addr  = waddr_q;
   assign o_Busy         = busy_q;
   assign o_Result_Valid = valid_q;
   assign o_Digit        = digit_q;
   assign o_Max_Score    = score_q;
   assign o_State        = led_q;

endmodule
